// File: rtl/shift_register_ctl_if.sv
// Bundle of controller-side strobes and shifter status for the I2C serial shifter.
// The controller FSM drives through master; the shifter implements slave.
interface shift_register_ctl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             load;
  logic [WIDTH-1:0] ins;
  logic             shift;
  logic             sdi;
  logic             abort;
  logic             sdo;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output load, ins, shift, sdi, abort,
    input  sdo, out, busy, done, bit_cnt
  );

  modport slave (
    input  load, ins, shift, sdi, abort,
    output sdo, out, busy, done, bit_cnt
  );
endinterface

// File: rtl/shift_register_ctl.sv
// Self-sequencing serial shifter: loads a word, shifts it out on sdo while capturing
// sdi, counts bits internally and pulses done after the last bit.
module shift_register_ctl #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input logic                 clock,
  input logic                 reset_n,
  shift_register_ctl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             sdo_reg, sdo_next;
  logic             done_reg, done_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] shifted;
  logic             next_bit;
  logic             first_bit;

  // Bit order only changes which end is shifted out and which end sdi enters.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shifted   = {out_reg[WIDTH-2:0], bus.sdi};
      assign next_bit  = out_reg[WIDTH-2];
      assign first_bit = bus.ins[WIDTH-1];
    end else begin : g_lsb
      assign shifted   = {bus.sdi, out_reg[WIDTH-1:1]};
      assign next_bit  = out_reg[1];
      assign first_bit = bus.ins[0];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      sdo_reg   <= 1'b1;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      sdo_reg   <= sdo_next;
      done_reg  <= done_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    sdo_next   = sdo_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          out_next   = bus.ins;
          cnt_next   = '0;
          sdo_next   = first_bit;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // abort beats a coincident shift so a lost arbitration never consumes a bit
        if (bus.abort) begin
          sdo_next   = 1'b1;
          state_next = IDLE;
        end else if (bus.shift) begin
          out_next = shifted;
          sdo_next = next_bit;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            sdo_next   = 1'b1;
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.sdo     = sdo_reg;
  assign bus.out     = out_reg;
  assign bus.busy    = (state_reg == SHIFT);
  assign bus.done    = done_reg;
  assign bus.bit_cnt = cnt_reg;
endmodule

// File: tb/tb_shift_register_ctl.sv
// Directed bench: vector table on an 8-bit MSB-first shifter, plus word sequences
// for LSB-first, back-to-back loads and 16-bit instances.
module tb_shift_register_ctl;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        shift = 1'b0;
  logic        sdi = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] ins = '0;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        sel_sdo, sel_busy, sel_done;
  logic [31:0] sel_out, sel_cnt;

  always #5 clock = ~clock;

  shift_register_ctl_if #(.WIDTH(8))  if_m8 ();
  shift_register_ctl_if #(.WIDTH(8))  if_l8 ();
  shift_register_ctl_if #(.WIDTH(16)) if_m16 ();
  shift_register_ctl_if #(.WIDTH(16)) if_l16 ();

  assign if_m8.load  = load;  assign if_m8.shift  = shift; assign if_m8.sdi  = sdi;
  assign if_m8.abort = abort; assign if_m8.ins    = ins[7:0];
  assign if_l8.load  = load;  assign if_l8.shift  = shift; assign if_l8.sdi  = sdi;
  assign if_l8.abort = abort; assign if_l8.ins    = ins[7:0];
  assign if_m16.load  = load;  assign if_m16.shift = shift; assign if_m16.sdi = sdi;
  assign if_m16.abort = abort; assign if_m16.ins   = ins;
  assign if_l16.load  = load;  assign if_l16.shift = shift; assign if_l16.sdi = sdi;
  assign if_l16.abort = abort; assign if_l16.ins   = ins;

  shift_register_ctl #(.WIDTH(8), .MSB_FIRST(1)) dut_m8 (
    .clock(clock), .reset_n(reset_n), .bus(if_m8.slave));
  shift_register_ctl #(.WIDTH(8), .MSB_FIRST(0)) dut_l8 (
    .clock(clock), .reset_n(reset_n), .bus(if_l8.slave));
  shift_register_ctl #(.WIDTH(16), .MSB_FIRST(1)) dut_m16 (
    .clock(clock), .reset_n(reset_n), .bus(if_m16.slave));
  shift_register_ctl #(.WIDTH(16), .MSB_FIRST(0)) dut_l16 (
    .clock(clock), .reset_n(reset_n), .bus(if_l16.slave));

  always_comb begin
    sel_sdo = if_m8.sdo; sel_busy = if_m8.busy; sel_done = if_m8.done;
    sel_out = 32'(if_m8.out); sel_cnt = 32'(if_m8.bit_cnt);
    case (sel)
      1: begin
        sel_sdo = if_l8.sdo; sel_busy = if_l8.busy; sel_done = if_l8.done;
        sel_out = 32'(if_l8.out); sel_cnt = 32'(if_l8.bit_cnt);
      end
      2: begin
        sel_sdo = if_m16.sdo; sel_busy = if_m16.busy; sel_done = if_m16.done;
        sel_out = 32'(if_m16.out); sel_cnt = 32'(if_m16.bit_cnt);
      end
      3: begin
        sel_sdo = if_l16.sdo; sel_busy = if_l16.busy; sel_done = if_l16.done;
        sel_out = 32'(if_l16.out); sel_cnt = 32'(if_l16.bit_cnt);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic       load;
    logic       shift;
    logic       sdi;
    logic       abort;
    logic [7:0] ins;
    logic       e_sdo;
    logic [7:0] e_out;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_cnt;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; load = 0; shift = 0; sdi = 0; abort = 0; ins = '0;
    tick();
    reset_n = 1'b1;
  endtask

  // Loads word, shifts width bits receiving rx, and returns in the done cycle.
  task automatic run_word(input int width, input bit msb, input logic [15:0] word,
                          input logic [15:0] rx, input string tag);
    int idx;
    load = 1'b1; ins = word;
    tick();
    load = 1'b0; ins = '0;
    check({tag, " load busy"}, 32'(sel_busy), 32'd1);
    for (int i = 0; i < width; i++) begin
      idx = msb ? (width - 1 - i) : i;
      check($sformatf("%s sdo bit %0d", tag, i), 32'(sel_sdo), 32'(word[idx]));
      check($sformatf("%s cnt bit %0d", tag, i), sel_cnt, 32'(i));
      sdi = rx[idx]; shift = 1'b1;
      tick();
      shift = 1'b0; sdi = 1'b0;
    end
    check({tag, " done"}, 32'(sel_done), 32'd1);
    check({tag, " out"},  sel_out, 32'(rx));
    check({tag, " sdo released"}, 32'(sel_sdo), 32'd1);
    check({tag, " final cnt"}, sel_cnt, 32'(width));
    check({tag, " busy clear"}, 32'(sel_busy), 32'd0);
    $display("word %s: out=%0h done=%0b", tag, sel_out, sel_done);
  endtask

  initial begin
    //         ld sh sd ab ins    sdo out    bsy dn cnt
    vecs = '{
      '{0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 4'd0},
      '{0, 1, 1, 0, 8'h00, 1, 8'h00, 0, 0, 4'd0},
      '{0, 0, 0, 1, 8'h00, 1, 8'h00, 0, 0, 4'd0},
      '{1, 0, 0, 0, 8'hA5, 1, 8'hA5, 1, 0, 4'd0},
      '{0, 1, 0, 0, 8'h00, 0, 8'h4A, 1, 0, 4'd1},
      '{0, 1, 0, 0, 8'h00, 1, 8'h94, 1, 0, 4'd2},
      '{0, 1, 1, 0, 8'h00, 0, 8'h29, 1, 0, 4'd3},
      '{0, 1, 1, 0, 8'h00, 0, 8'h53, 1, 0, 4'd4},
      '{0, 1, 1, 0, 8'h00, 1, 8'hA7, 1, 0, 4'd5},
      '{0, 0, 1, 0, 8'h00, 1, 8'hA7, 1, 0, 4'd5},
      '{0, 1, 1, 0, 8'h00, 0, 8'h4F, 1, 0, 4'd6},
      '{0, 1, 0, 0, 8'h00, 1, 8'h9E, 1, 0, 4'd7},
      '{0, 1, 0, 0, 8'h00, 1, 8'h3C, 0, 1, 4'd8},
      '{0, 0, 0, 0, 8'h00, 1, 8'h3C, 0, 0, 4'd8},
      '{1, 0, 0, 0, 8'h96, 1, 8'h96, 1, 0, 4'd0},
      '{0, 1, 1, 0, 8'h00, 0, 8'h2D, 1, 0, 4'd1},
      '{0, 1, 0, 0, 8'h00, 0, 8'h5A, 1, 0, 4'd2},
      '{0, 1, 1, 0, 8'h00, 1, 8'hB5, 1, 0, 4'd3},
      '{0, 1, 0, 1, 8'h00, 1, 8'hB5, 0, 0, 4'd3},
      '{0, 0, 0, 0, 8'h00, 1, 8'hB5, 0, 0, 4'd3},
      '{1, 1, 1, 0, 8'h5A, 0, 8'h5A, 1, 0, 4'd0},
      '{1, 0, 0, 0, 8'hFF, 0, 8'h5A, 1, 0, 4'd0},
      '{1, 1, 0, 0, 8'hFF, 1, 8'hB4, 1, 0, 4'd1},
      '{0, 0, 0, 1, 8'h00, 1, 8'hB4, 0, 0, 4'd1},
      '{0, 1, 1, 0, 8'h00, 1, 8'hB4, 0, 0, 4'd1}
    };

    // Reset held two cycles under random inputs
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      load = 1'($urandom); shift = 1'($urandom); sdi = 1'($urandom);
      abort = 1'($urandom); ins = 16'($urandom);
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #0;
      check($sformatf("reset out dut%0d", s),  sel_out, 32'd0);
      check($sformatf("reset sdo dut%0d", s),  32'(sel_sdo), 32'd1);
      check($sformatf("reset busy dut%0d", s), 32'(sel_busy), 32'd0);
      check($sformatf("reset done dut%0d", s), 32'(sel_done), 32'd0);
      check($sformatf("reset cnt dut%0d", s),  sel_cnt, 32'd0);
    end

    do_reset();
    sel = 0;
    for (int v = 0; v < NVEC; v++) begin
      load = vecs[v].load; shift = vecs[v].shift; sdi = vecs[v].sdi;
      abort = vecs[v].abort; ins = {8'h00, vecs[v].ins};
      tick();
      check($sformatf("vec%0d sdo", v),  32'(sel_sdo),  32'(vecs[v].e_sdo));
      check($sformatf("vec%0d out", v),  sel_out,       32'(vecs[v].e_out));
      check($sformatf("vec%0d busy", v), 32'(sel_busy), 32'(vecs[v].e_busy));
      check($sformatf("vec%0d done", v), 32'(sel_done), 32'(vecs[v].e_done));
      check($sformatf("vec%0d cnt", v),  sel_cnt,       32'(vecs[v].e_cnt));
      $display("vec %0d: sdo=%0b out=%0h busy=%0b done=%0b cnt=%0d",
               v, sel_sdo, sel_out, sel_busy, sel_done, sel_cnt);
    end
    load = 0; shift = 0; sdi = 0; abort = 0; ins = '0;

    // LSB-first word, then confirm done is a single pulse
    do_reset();
    sel = 1;
    run_word(8, 1'b0, 16'h00A5, 16'h003C, "l8");
    tick();
    check("l8 done one cycle", 32'(sel_done), 32'd0);
    check("l8 out holds", sel_out, 32'h3C);

    // Back-to-back words: the second load lands in the done cycle
    do_reset();
    sel = 0;
    run_word(8, 1'b1, 16'h00A5, 16'h003C, "m8 w1");
    run_word(8, 1'b1, 16'h00C3, 16'h005A, "m8 w2");
    tick();
    check("m8 b2b done clear", 32'(sel_done), 32'd0);

    do_reset();
    sel = 2;
    run_word(16, 1'b1, 16'hA55A, 16'h1234, "m16 w1");
    run_word(16, 1'b1, 16'h8001, 16'hBEEF, "m16 w2");
    tick();
    check("m16 b2b done clear", 32'(sel_done), 32'd0);

    do_reset();
    sel = 3;
    run_word(16, 1'b0, 16'hA55A, 16'h1234, "l16 w1");
    run_word(16, 1'b0, 16'h8001, 16'hBEEF, "l16 w2");
    tick();
    check("l16 b2b done clear", 32'(sel_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
